// File: rtl/sd_bd_seq_pkg.sv
// Shared types and constants for the SD buffer-descriptor sequencer.
package sd_bd_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLaunch,
    StWait,
    StRetire,
    StGap
  } seq_state_e;

  // BD word order as laid out in the store.
  localparam logic [1:0] WordSysLo = 2'd0;
  localparam logic [1:0] WordSysHi = 2'd1;
  localparam logic [1:0] WordBlkLo = 2'd2;
  localparam logic [1:0] WordBlkHi = 2'd3;

  localparam int unsigned BdNumDefault    = 16;
  localparam int unsigned MaxRetryDefault = 3;

endpackage

// File: rtl/sd_xfer_watchdog.sv
// Transfer watchdog: counts while enabled, terminal count flags a stalled transfer.
module sd_xfer_watchdog #(
  parameter int unsigned TMO_W   = 20,
  parameter int unsigned TMO_CYC = 20'hFFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign tc = en && (cnt == TMO_W'(TMO_CYC - 1));

endmodule

// File: rtl/sd_bd_sequencer.sv
// Fetches BDs from the store, launches and supervises one SD transfer per BD,
// then retires it with a handshaked completion toward the store.
module sd_bd_sequencer
  import sd_bd_seq_pkg::*;
#(
  parameter int unsigned BD_W      = 5,
  parameter int unsigned BD_NUM    = BdNumDefault,
  parameter int unsigned MAX_RETRY = MaxRetryDefault,
  parameter int unsigned TMO_W     = 20,
  parameter int unsigned TMO_CYC   = 20'hFFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            abort,
  input  logic            sts_clr,
  input  logic [BD_W-1:0] free_bd,
  output logic            bd_re,
  input  logic            bd_ack,
  input  logic [15:0]     bd_dat,
  output logic            bd_cmp,
  output logic            xfer_start,
  output logic            xfer_stop,
  output logic [31:0]     xfer_sys_addr,
  output logic [31:0]     xfer_blk_addr,
  input  logic            xfer_done,
  input  logic            xfer_err,
  output logic            busy,
  output logic            sts_cmp,
  output logic            sts_err,
  output logic            sts_abort,
  output logic [1:0]      retry_cnt
);

  localparam logic [BD_W-1:0] BdFull = BD_W'(BD_NUM);

  seq_state_e      state;
  logic [1:0]      idx;
  logic            abort_lat;
  logic [BD_W-1:0] f0;
  logic            wd_tc;

  sd_xfer_watchdog #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clr(state == StLaunch),
    .en (state == StWait),
    .tc (wd_tc)
  );

  assign busy = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      idx           <= WordSysLo;
      abort_lat     <= 1'b0;
      f0            <= '0;
      bd_re         <= 1'b0;
      bd_cmp        <= 1'b0;
      xfer_start    <= 1'b0;
      xfer_stop     <= 1'b0;
      xfer_sys_addr <= '0;
      xfer_blk_addr <= '0;
      sts_cmp       <= 1'b0;
      sts_err       <= 1'b0;
      sts_abort     <= 1'b0;
      retry_cnt     <= '0;
    end else begin
      xfer_start <= 1'b0;
      xfer_stop  <= 1'b0;
      // Set events below are assigned later and therefore win over a clear.
      if (sts_clr) begin
        sts_cmp   <= 1'b0;
        sts_err   <= 1'b0;
        sts_abort <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (enable && (free_bd != BdFull)) begin
            state     <= StFetch;
            idx       <= WordSysLo;
            abort_lat <= 1'b0;
            bd_re     <= 1'b1;
          end
        end

        StFetch: begin
          if (abort) abort_lat <= 1'b1;
          if (bd_re) begin
            bd_re <= 1'b0;
          end else if (bd_ack) begin
            unique case (idx)
              WordSysLo: xfer_sys_addr[15:0]  <= bd_dat;
              WordSysHi: xfer_sys_addr[31:16] <= bd_dat;
              WordBlkLo: xfer_blk_addr[15:0]  <= bd_dat;
              WordBlkHi: xfer_blk_addr[31:16] <= bd_dat;
            endcase
            if (idx == WordBlkHi) begin
              if (abort_lat || abort) begin
                sts_abort <= 1'b1;
                bd_cmp    <= 1'b1;
                f0        <= free_bd;
                state     <= StRetire;
              end else begin
                state <= StLaunch;
              end
            end else begin
              idx   <= idx + 2'd1;
              bd_re <= 1'b1;
            end
          end
        end

        StLaunch: begin
          xfer_start <= 1'b1;
          state      <= StWait;
        end

        StWait: begin
          if (abort) begin
            xfer_stop <= 1'b1;
            sts_abort <= 1'b1;
            bd_cmp    <= 1'b1;
            f0        <= free_bd;
            state     <= StRetire;
          end else if (xfer_done && !xfer_err) begin
            sts_cmp <= 1'b1;
            bd_cmp  <= 1'b1;
            f0      <= free_bd;
            state   <= StRetire;
          end else if (xfer_err || wd_tc) begin
            // Only a timeout leaves the engine running and needs cancelling.
            xfer_stop <= !xfer_err;
            if (32'(retry_cnt) < MAX_RETRY) begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= StLaunch;
            end else begin
              sts_err <= 1'b1;
              bd_cmp  <= 1'b1;
              f0      <= free_bd;
              state   <= StRetire;
            end
          end
        end

        StRetire: begin
          // A BD written by the host in the same cycle masks the completion.
          if (free_bd == f0 + BD_W'(1)) begin
            bd_cmp <= 1'b0;
            state  <= StGap;
          end else if (free_bd < f0) begin
            f0 <= free_bd;
          end
        end

        StGap: begin
          retry_cnt <= '0;
          state     <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_bd_sequencer.sv
// Directed self-checking bench for sd_bd_sequencer with a small BD-store read model.
module tb_sd_bd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        sts_clr = 1'b0;
  logic [4:0]  free_bd = 5'd16;
  logic        bd_re;
  logic        bd_ack = 1'b0;
  logic [15:0] bd_dat = 16'h0;
  logic        bd_cmp;
  logic        xfer_start;
  logic        xfer_stop;
  logic [31:0] xfer_sys_addr;
  logic [31:0] xfer_blk_addr;
  logic        xfer_done = 1'b0;
  logic        xfer_err = 1'b0;
  logic        busy;
  logic        sts_cmp;
  logic        sts_err;
  logic        sts_abort;
  logic [1:0]  retry_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] words [4];
  int          rd_cnt = 0;
  logic        re_s;

  sd_bd_sequencer #(
    .BD_W     (5),
    .BD_NUM   (16),
    .MAX_RETRY(3),
    .TMO_W    (20),
    .TMO_CYC  (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .abort        (abort),
    .sts_clr      (sts_clr),
    .free_bd      (free_bd),
    .bd_re        (bd_re),
    .bd_ack       (bd_ack),
    .bd_dat       (bd_dat),
    .bd_cmp       (bd_cmp),
    .xfer_start   (xfer_start),
    .xfer_stop    (xfer_stop),
    .xfer_sys_addr(xfer_sys_addr),
    .xfer_blk_addr(xfer_blk_addr),
    .xfer_done    (xfer_done),
    .xfer_err     (xfer_err),
    .busy         (busy),
    .sts_cmp      (sts_cmp),
    .sts_err      (sts_err),
    .sts_abort    (sts_abort),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  // Store read port: ack and data one cycle after each read strobe.
  always @(posedge clk) begin
    re_s = bd_re;
    #1;
    bd_ack = re_s;
    if (re_s) begin
      bd_dat = words[rd_cnt % 4];
      rd_cnt = rd_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_bd(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3, output int lat);
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    words[3] = w3;
    free_bd = 5'd15;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (xfer_start) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_err();
    xfer_err = 1'b1;
    tick();
    xfer_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bd_re, bd_cmp, xfer_start, xfer_stop, busy, sts_cmp, sts_err, sts_abort, retry_cnt}
        !== 10'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0", {bd_re, bd_cmp, xfer_start, xfer_stop, busy,
               sts_cmp, sts_err, sts_abort, retry_cnt});
    end
    checks++;
    if ({xfer_sys_addr, xfer_blk_addr} !== 64'd0) begin
      failures++;
      $display("FAIL reset_addr: got %h %h want 0", xfer_sys_addr, xfer_blk_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    free_bd = 5'd15;
    repeat (3) tick();
    checks++;
    if ({busy, bd_re} !== 2'b00) begin
      failures++;
      $display("FAIL enable_low_idle: got busy/re %b want 00", {busy, bd_re});
    end
    free_bd = 5'd16;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_fetch_launch();
    int lat;
    int rd0;
    rd0 = rd_cnt;
    start_bd(16'h1000, 16'h0000, 16'h0040, 16'h0000, lat);
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL launch_latency: got %0d want 10", lat);
    end
    checks++;
    if (xfer_sys_addr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL sys_addr: got %h want 00001000", xfer_sys_addr);
    end
    checks++;
    if (xfer_blk_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL blk_addr: got %h want 00000040", xfer_blk_addr);
    end
    checks++;
    if (rd_cnt - rd0 != 4) begin
      failures++;
      $display("FAIL fetch_reads: got %0d want 4", rd_cnt - rd0);
    end
    tick();
    checks++;
    if ({xfer_start, busy} !== 2'b01) begin
      failures++;
      $display("FAIL start_one_cycle: got start/busy %b want 01", {xfer_start, busy});
    end
  endtask

  task automatic test_complete();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    checks++;
    if ({bd_cmp, sts_cmp, sts_err} !== 3'b110) begin
      failures++;
      $display("FAIL done_retire: got cmp/sts_cmp/sts_err %b want 110", {bd_cmp, sts_cmp, sts_err});
    end
    free_bd = 5'd16;
    tick();
    checks++;
    if ({bd_cmp, busy} !== 2'b01) begin
      failures++;
      $display("FAIL bd_cmp_one_cycle: got cmp/busy %b want 01", {bd_cmp, busy});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_retry();
    int lat;
    int starts;
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    checks++;
    if (sts_cmp !== 1'b0) begin
      failures++;
      $display("FAIL sts_clr: got %b want 0", sts_cmp);
    end
    start_bd(16'hBEEF, 16'hDEAD, 16'h5678, 16'h1234, lat);
    starts = (lat != 0) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      pulse_err();
      tick();
      if (xfer_start) starts++;
    end
    checks++;
    if (starts != 4) begin
      failures++;
      $display("FAIL retry_starts: got %0d want 4", starts);
    end
    checks++;
    if (retry_cnt !== 2'd3) begin
      failures++;
      $display("FAIL retry_cnt_max: got %0d want 3", retry_cnt);
    end
    checks++;
    if ({xfer_sys_addr, xfer_blk_addr} !== 64'hDEADBEEF_12345678) begin
      failures++;
      $display("FAIL retry_addr: got %h %h want deadbeef 12345678", xfer_sys_addr, xfer_blk_addr);
    end
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    checks++;
    if ({bd_cmp, sts_cmp, sts_err} !== 3'b110) begin
      failures++;
      $display("FAIL retry_then_done: got cmp/sts_cmp/sts_err %b want 110",
               {bd_cmp, sts_cmp, sts_err});
    end
    free_bd = 5'd16;
    tick();
    tick();
    checks++;
    if ({busy, retry_cnt} !== 3'b000) begin
      failures++;
      $display("FAIL retry_cleared: got busy/retry %b want 000", {busy, retry_cnt});
    end

    // Fourth error gives up; a clear in the same cycle loses to the set.
    start_bd(16'h0001, 16'h0002, 16'h0003, 16'h0004, lat);
    for (int i = 0; i < 3; i++) begin
      pulse_err();
      tick();
    end
    sts_clr = 1'b1;
    xfer_err = 1'b1;
    tick();
    sts_clr = 1'b0;
    xfer_err = 1'b0;
    checks++;
    if ({bd_cmp, sts_err, sts_cmp, xfer_start} !== 4'b1100) begin
      failures++;
      $display("FAIL give_up: got cmp/sts_err/sts_cmp/start %b want 1100",
               {bd_cmp, sts_err, sts_cmp, xfer_start});
    end
    free_bd = 5'd16;
    tick();
    tick();
  endtask

  task automatic test_timeout_abort();
    int lat;
    int m;
    int starts;
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    start_bd(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, lat);
    m = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (xfer_stop) begin
        m = i;
        break;
      end
    end
    checks++;
    if (m != 100) begin
      failures++;
      $display("FAIL timeout_cycles: got %0d want 100", m);
    end
    tick();
    checks++;
    if ({xfer_start, retry_cnt, sts_err} !== 4'b1010) begin
      failures++;
      $display("FAIL timeout_relaunch: got start/retry/err %b want 1010",
               {xfer_start, retry_cnt, sts_err});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({xfer_stop, sts_abort, bd_cmp, sts_cmp} !== 4'b1110) begin
      failures++;
      $display("FAIL wait_abort: got stop/abort/cmp/sts_cmp %b want 1110",
               {xfer_stop, sts_abort, bd_cmp, sts_cmp});
    end
    free_bd = 5'd16;
    starts = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (xfer_start) starts++;
    end
    checks++;
    if (starts != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_start: got starts=%0d busy=%b want 0 0", starts, busy);
    end
  endtask

  task automatic test_fetch_abort();
    int rd0;
    int starts;
    rd0 = rd_cnt;
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    words[3] = 16'h4444;
    free_bd = 5'd15;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (xfer_start) starts++;
      if (bd_cmp) break;
    end
    checks++;
    if (rd_cnt - rd0 != 4) begin
      failures++;
      $display("FAIL abort_fetch_reads: got %0d want 4", rd_cnt - rd0);
    end
    checks++;
    if (starts != 0 || bd_cmp !== 1'b1) begin
      failures++;
      $display("FAIL abort_fetch_retire: got starts=%0d cmp=%b want 0 1", starts, bd_cmp);
    end
    free_bd = 5'd16;
    tick();
    tick();
  endtask

  task automatic test_retire_drop();
    int lat;
    start_bd(16'h0100, 16'h0000, 16'h0200, 16'h0000, lat);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    free_bd = 5'd14;
    repeat (3) tick();
    checks++;
    if (bd_cmp !== 1'b1) begin
      failures++;
      $display("FAIL retire_hold_on_drop: got %b want 1", bd_cmp);
    end
    free_bd = 5'd15;
    tick();
    checks++;
    if (bd_cmp !== 1'b0) begin
      failures++;
      $display("FAIL retire_after_relatch: got %b want 0", bd_cmp);
    end
    tick();
  endtask

  task automatic test_rst_mid_wait();
    int lat;
    start_bd(16'hCAFE, 16'h0BAD, 16'hFACE, 16'h0001, lat);
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL back_to_back_latency: got %0d want 10", lat);
    end
    tick();
    tick();
    checks++;
    if ({busy, xfer_sys_addr} !== {1'b1, 32'h0BAD_CAFE}) begin
      failures++;
      $display("FAIL pre_reset_wait: got busy=%b sys=%h want 1 0badcafe", busy, xfer_sys_addr);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bd_re, bd_cmp, xfer_start, xfer_stop, busy, sts_cmp, sts_err, sts_abort, retry_cnt,
         xfer_sys_addr, xfer_blk_addr} !== 74'd0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b sts_cmp=%b sys=%h blk=%h want all 0",
               busy, sts_cmp, xfer_sys_addr, xfer_blk_addr);
    end
    @(negedge clk);
    free_bd = 5'd16;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_fetch_launch();
    test_complete();
    test_retry();
    test_timeout_abort();
    test_fetch_abort();
    test_retire_drop();
    test_rst_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
